// File: rtl/run_len_seq.sv
// Bit-serial sequencer: longest run of 1s/0s, popcount or trailing-zero count
// over a 32-bit operand, one bit per cycle LSB first, with abort and early exit.
module run_len_seq #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [5:0]  result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] sh_reg, sh_next;
  logic [1:0]  op_reg, op_next;
  logic [5:0]  idx_reg, idx_next;
  logic [5:0]  cur_reg, cur_next;
  logic [5:0]  best_reg, best_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [5:0]  result_reg, result_next;
  logic        tz_found_reg, tz_found_next;

  logic        bit_cur;
  logic        match;
  logic        last_bit;
  logic        early;
  logic [31:0] sh_shift;
  logic [5:0]  run_len;
  logic [5:0]  best_upd;
  logic [5:0]  cnt_upd;
  logic [5:0]  final_val;

  assign bit_cur  = sh_reg[0];
  assign sh_shift = {1'b0, sh_reg[31:1]};
  // op 01 looks for zeros, op 00 for ones
  assign match    = op_reg[0] ? ~bit_cur : bit_cur;
  assign run_len  = match ? (cur_reg + 6'd1) : 6'd0;
  assign best_upd = (run_len > best_reg) ? run_len : best_reg;
  assign last_bit = (idx_reg == 6'd31);

  always_comb begin
    cnt_upd = cnt_reg;
    if (op_reg == 2'b10) begin
      cnt_upd = cnt_reg + {5'd0, bit_cur};
    end else if (op_reg == 2'b11 && !tz_found_reg && !bit_cur) begin
      cnt_upd = cnt_reg + 6'd1;
    end
  end

  assign final_val = op_reg[1] ? cnt_upd : best_upd;

  // Once the remaining bits are all zero, neither the longest 1-run nor the
  // popcount can grow; the trailing-zero count is settled by its first 1.
  generate
    if (EARLY_EXIT) begin : g_early
      assign early = ((op_reg == 2'b00 || op_reg == 2'b10) && (sh_shift == 32'd0)) ||
                     ((op_reg == 2'b11) && bit_cur);
    end else begin : g_no_early
      assign early = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    op_next       = op_reg;
    idx_next      = idx_reg;
    cur_next      = cur_reg;
    best_next     = best_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    tz_found_next = tz_found_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_next    = RUN;
          sh_next       = data_in;
          op_next       = op;
          idx_next      = 6'd0;
          cur_next      = 6'd0;
          best_next     = 6'd0;
          cnt_next      = 6'd0;
          tz_found_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          sh_next  = sh_shift;
          idx_next = idx_reg + 6'd1;
          if (!op_reg[1]) begin
            cur_next  = run_len;
            best_next = best_upd;
          end
          cnt_next = cnt_upd;
          if (op_reg == 2'b11 && bit_cur) begin
            tz_found_next = 1'b1;
          end
          if (last_bit || early) begin
            state_next  = DONE;
            result_next = final_val;
          end else begin
            state_next = RUN;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      sh_reg       <= 32'd0;
      op_reg       <= 2'd0;
      idx_reg      <= 6'd0;
      cur_reg      <= 6'd0;
      best_reg     <= 6'd0;
      cnt_reg      <= 6'd0;
      result_reg   <= 6'd0;
      tz_found_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      op_reg       <= op_next;
      idx_reg      <= idx_next;
      cur_reg      <= cur_next;
      best_reg     <= best_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      tz_found_reg <= tz_found_next;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_run_len_seq.sv
// Self-checking bench: two instances (no early exit / early exit) share stimulus
// and are compared against a bit-level reference of each operation.
module tb_run_len_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic        abort;
  logic        busy0, done0, busy1, done1;
  logic [5:0]  result0, result1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PAT_A = 32'h03F80F50;
  localparam logic [31:0] PAT_B = 32'hF0F00FF1;

  run_len_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .abort(abort), .busy(busy0), .done(done0), .result(result0)
  );

  run_len_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .abort(abort), .busy(busy1), .done(done1), .result(result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Longest run of ones: each x & (x>>1) shortens every run by one.
  function automatic int longest_ones(input logic [31:0] x);
    int n;
    logic [31:0] v;
    n = 0;
    v = x;
    while (v != 32'd0) begin
      v = v & (v >> 1);
      n++;
    end
    return n;
  endfunction

  function automatic int lowest_one(input logic [31:0] x);
    for (int i = 0; i < 32; i++) if (x[i]) return i;
    return 32;
  endfunction

  function automatic int highest_one(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) if (x[i]) return i;
    return -1;
  endfunction

  function automatic logic [5:0] ref_result(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'b00:   return 6'(longest_ones(d));
      2'b01:   return 6'(longest_ones(~d));
      2'b10:   return 6'($countones(d));
      default: return 6'(lowest_one(d));
    endcase
  endfunction

  // Busy length of the early-exit instance.
  function automatic int ref_lat_ee(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'b00, 2'b10: return (d == 32'd0) ? 1 : highest_one(d) + 1;
      2'b01:        return 32;
      default:      return (d == 32'd0) ? 32 : lowest_one(d) + 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] d, input logic [1:0] o,
                        input logic [5:0] exp_res, input int exp_lat1);
    int b0, b1, dc0, dc1, dn0, dn1;
    logic [5:0] r0, r1;
    b0 = 0; b1 = 0; dc0 = -1; dc1 = -1; dn0 = 0; dn1 = 0;
    r0 = 6'd0; r1 = 6'd0;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d;
    @(negedge clk);
    start = 1'b0; data_in = $urandom;
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) @(negedge clk);
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0) begin dn0++; dc0 = c; r0 = result0; end
      if (done1) begin dn1++; dc1 = c; r1 = result1; end
    end
    check("busy0_cycles", b0, 32);
    check("done0_cycle", dc0, 33);
    check("done0_pulses", dn0, 1);
    check("result0", r0, exp_res);
    check("result0_hold", result0, exp_res);
    check("busy1_cycles", b1, exp_lat1);
    check("done1_cycle", dc1, exp_lat1 + 1);
    check("result1", r1, exp_res);
    $display("op=%0d data=%08h exp=%0d | dut0 res=%0d busy=%0d | dut1 res=%0d busy=%0d",
             o, d, exp_res, r0, b0, r1, b1);
  endtask

  initial begin
    int n0, n1, run;
    logic [31:0] d;
    logic [1:0]  o;

    reset = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; data_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_result0", result0, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_result1", result1, 0);
    reset = 1'b1;

    // Reference operand, every op
    run_op(PAT_A, 2'b00, 6'd7,  ref_lat_ee(PAT_A, 2'b00));
    run_op(PAT_A, 2'b01, 6'd7,  32);
    run_op(PAT_A, 2'b10, 6'd13, ref_lat_ee(PAT_A, 2'b10));
    run_op(PAT_A, 2'b11, 6'd4,  5);

    // Boundaries
    run_op(32'hFFFFFFFF, 2'b00, 6'd32, 32);
    run_op(32'h00000000, 2'b11, 6'd32, 32);
    run_op(32'h00000000, 2'b00, 6'd0,  1);
    run_op(32'h00000001, 2'b10, 6'd1,  1);
    run_op(32'h00000100, 2'b11, 6'd8,  9);
    run_op(32'h80000000, 2'b01, 6'd31, 32);

    // Back-to-back with start held high, alternating operands
    n0 = 0; n1 = 0; run = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b01; data_in = PAT_A;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy0) run++;
      if (done1) n1++;
      if (done0) begin
        check("b2b_result", result0, ref_result((n0 % 2) ? PAT_B : PAT_A, 2'b01));
        check("b2b_spacing", c, 33 * (n0 + 1));
        check("b2b_busy", run, 32);
        $display("b2b done #%0d at cycle %0d result=%0d", n0, c, result0);
        run = 0;
        n0++;
        data_in = (n0 % 2) ? PAT_B : PAT_A;
        if (n0 == 3) start = 1'b0;
      end
    end
    check("b2b_done0_count", n0, 3);
    check("b2b_done1_count", n1, 3);
    check("b2b_idle", busy0, 0);

    // Abort mid-run after a result of 7
    run_op(PAT_A, 2'b00, 6'd7, ref_lat_ee(PAT_A, 2'b00));
    @(negedge clk);
    start = 1'b1; op = 2'b10; data_in = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy0", busy0, 0);
    check("abort_busy1", busy1, 0);
    check("abort_done0", done0, 0);
    check("abort_result0", result0, 7);
    check("abort_result1", result1, 7);
    n0 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0 || done1 || busy0) n0++;
    end
    check("abort_quiet", n0, 0);
    $display("abort at run cycle 10: result0=%0d result1=%0d", result0, result1);

    // Start and abort together: start dropped
    start = 1'b1; abort = 1'b1; op = 2'b00; data_in = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("startabort_busy0", busy0, 0);
    check("startabort_busy1", busy1, 0);
    @(negedge clk);
    check("startabort_done0", done0, 0);
    check("startabort_result0", result0, 7);
    $display("start+abort: busy0=%0d result0=%0d", busy0, result0);

    // Reset in the middle of a run
    start = 1'b1; op = 2'b00; data_in = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 20; c++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_busy0", busy0, 0);
    check("midrst_done0", done0, 0);
    check("midrst_result0", result0, 0);
    check("midrst_busy1", busy1, 0);
    check("midrst_result1", result1, 0);
    $display("reset at run cycle 20: busy0=%0d result0=%0d", busy0, result0);
    run_op(PAT_A, 2'b10, 6'd13, ref_lat_ee(PAT_A, 2'b10));

    // Randomized operands, shaped to exercise early exit
    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      case (i % 4)
        1: d = d >> $urandom_range(0, 31);
        2: d = d << $urandom_range(0, 31);
        3: d = d & $urandom & $urandom;
        default: ;
      endcase
      o = 2'($urandom_range(0, 3));
      run_op(d, o, ref_result(d, o), ref_lat_ee(d, o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
